l2_req_arbiter: RTL and testbench

L2_REQ_ARBITER -- requirements
Module: l2_req_arbiter

---
 rtl/l2_req_arbiter_if.sv | 31 +++
 rtl/l2_req_arbiter.sv | 139 +++++++++++++
 tb/tb_l2_req_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_req_arbiter_if.sv
// Request/response bundle between the I/D/cache-op requesters, the L2 controller and l2_req_arbiter.
interface l2_req_arbiter_if;
  logic       i_req;
  logic       d_req;
  logic       d_we;
  logic       op_req;
  logic [6:0] op_code;
  logic       l2_init;
  logic       l2_ready_i;
  logic       l2_ready_d;
  logic       l2_ready_op;
  logic       i_op;
  logic [1:0] d_op;
  logic [6:0] op;
  logic       i_ack;
  logic       d_ack;
  logic       op_ack;
  logic [1:0] grant;
  logic       busy;
  logic       wd_err;

  modport master (
    output i_req, d_req, d_we, op_req, op_code, l2_init, l2_ready_i, l2_ready_d, l2_ready_op,
    input  i_op, d_op, op, i_ack, d_ack, op_ack, grant, busy, wd_err
  );

  modport slave (
    input  i_req, d_req, d_we, op_req, op_code, l2_init, l2_ready_i, l2_ready_d, l2_ready_op,
    output i_op, d_op, op, i_ack, d_ack, op_ack, grant, busy, wd_err
  );
endinterface

// File: rtl/l2_req_arbiter.sv
// L2 request arbiter: OP > I/D, one owner at a time, per-grant watchdog, one RELEASE cycle after every grant.
// I/D arbitration is fixed D>I with starvation relief, or round-robin when L2ARB_ROUND_ROBIN_EN is defined.
module l2_req_arbiter #(
  parameter int unsigned WD_LIMIT   = 255,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  l2_req_arbiter_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_G_OP, S_G_I, S_G_D, S_RELEASE} state_t;

  localparam logic [15:0] WD_LAST = 16'(WD_LIMIT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wd_cnt;
  logic        seen_low;
  logic        dwe_lat;
  logic [6:0]  op_lat;
  logic        in_grant;
  logic        done;
  logic        timeout;
  logic        pick_i;
  logic [1:0]  grant_c;

`ifdef L2ARB_ROUND_ROBIN_EN
  logic last_d;

  always_comb pick_i = bus.i_req && (!bus.d_req || last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (state == S_IDLE && state_nxt == S_G_D) begin
      last_d <= 1'b1;
    end else if (state == S_IDLE && state_nxt == S_G_I) begin
      last_d <= 1'b0;
    end
  end
`else
  localparam int SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;

  always_comb pick_i = bus.i_req && (!bus.d_req || starve_cnt == SMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!bus.i_req || (state == S_IDLE && state_nxt == S_G_I)) begin
      starve_cnt <= '0;
    end else if (state == S_IDLE && state_nxt == S_G_D && starve_cnt != SMAX) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wd_cnt   <= '0;
      seen_low <= 1'b0;
      dwe_lat  <= 1'b0;
      op_lat   <= '0;
    end else begin
      state <= state_nxt;
      // Request attributes are captured while idle so a requester dropping mid-grant cannot disturb the L2.
      if (state == S_IDLE) begin
        wd_cnt   <= '0;
        seen_low <= 1'b0;
        dwe_lat  <= bus.d_we;
        op_lat   <= bus.op_code;
      end else if (in_grant) begin
        wd_cnt <= wd_cnt + 16'd1;
        if (state == S_G_OP && !bus.l2_ready_op) begin
          seen_low <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    in_grant    = (state == S_G_OP) || (state == S_G_I) || (state == S_G_D);
    done        = 1'b0;
    grant_c     = 2'd0;
    bus.i_op    = 1'b0;
    bus.d_op    = 2'b00;
    bus.op      = 7'h00;
    bus.i_ack   = 1'b0;
    bus.d_ack   = 1'b0;
    bus.op_ack  = 1'b0;
    timeout     = in_grant && (wd_cnt == WD_LAST);
    case (state)
      S_IDLE: begin
        if (bus.l2_init) begin
          if (bus.op_req) begin
            state_nxt = S_G_OP;
          end else if (pick_i) begin
            state_nxt = S_G_I;
          end else if (bus.d_req) begin
            state_nxt = S_G_D;
          end
        end
      end
      S_G_OP: begin
        grant_c    = 2'd3;
        bus.op     = op_lat;
        // A ready left high from a previous op must fall before it can complete this one.
        done       = bus.l2_ready_op && seen_low;
        bus.op_ack = done && !rst;
      end
      S_G_I: begin
        grant_c   = 2'd1;
        bus.i_op  = 1'b1;
        done      = bus.l2_ready_i;
        bus.i_ack = done && !rst;
      end
      S_G_D: begin
        grant_c   = 2'd2;
        bus.d_op  = {dwe_lat, ~dwe_lat};
        done      = bus.l2_ready_d;
        bus.d_ack = done && !rst;
      end
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (in_grant && (done || timeout)) begin
      state_nxt = S_RELEASE;
    end
    bus.wd_err = timeout && !done && !rst;
    bus.grant  = grant_c;
    bus.busy   = (grant_c != 2'd0);
  end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Self-checking bench for l2_req_arbiter: table-driven single transactions plus multi-cycle sequences.
module tb_l2_req_arbiter;

  localparam int WD = 255;
  localparam int SM = 4;
  localparam int K_I  = 0;
  localparam int K_D  = 1;
  localparam int K_OP = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_req_arbiter_if bus();

  l2_req_arbiter #(.WD_LIMIT(WD), .STARVE_MAX(SM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] grant;
    logic       i_op;
    logic [1:0] d_op;
    logic [6:0] op;
    logic [2:0] ack;
    logic       wd;
    int         len;
  } sb_t;

  typedef struct {
    string      name;
    int         kind;
    logic       d_we;
    logic [6:0] op_code;
    int         delay;
    logic       drop;
    logic [1:0] exp_grant;
    logic       exp_i_op;
    logic [1:0] exp_d_op;
    logic [6:0] exp_op;
    logic [2:0] exp_ack;
  } txn_t;

  sb_t  sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic sb_t mk(input logic [1:0] g, input logic dwe, input logic [6:0] opc, input int len);
    sb_t e;
    e.grant = g;
    e.i_op  = (g == 2'd1);
    e.d_op  = (g == 2'd2) ? {dwe, ~dwe} : 2'b00;
    e.op    = (g == 2'd3) ? opc : 7'h00;
    e.ack   = (g == 2'd1) ? 3'b001 : (g == 2'd2) ? 3'b010 : 3'b100;
    e.wd    = 1'b0;
    e.len   = len;
    return e;
  endfunction

  // Scoreboard monitor: pops one expectation per completion or watchdog event.
  int         glen = 0;
  int         zlen = 100;
  logic [1:0] gprev = 2'd0;
  logic       held_bad = 1'b0;
  logic [9:0] first_out = '0;

  always @(negedge clk) begin
    logic [2:0] ack;
    logic [9:0] outs;
    sb_t        e;
    ack  = {bus.op_ack, bus.d_ack, bus.i_ack};
    outs = {bus.i_op, bus.d_op, bus.op};
    if (bus.grant != 2'd0) begin
      if (gprev == 2'd0) begin
        glen      = 0;
        first_out = outs;
        held_bad  = 1'b0;
        check("gap_between_grants", 32'(zlen >= 2), 32'd1);
      end else if (outs != first_out) begin
        held_bad = 1'b1;
      end
      glen++;
      if (ack != 3'b000 || bus.wd_err) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_completion: got grant=%0d ack=%b wd_err=%b expected none", bus.grant, ack, bus.wd_err);
        end else begin
          e = sbq.pop_front();
          check("sb_grant", 32'(bus.grant), 32'(e.grant));
          check("sb_outputs", 32'(outs), 32'({e.i_op, e.d_op, e.op}));
          check("sb_ack", 32'(ack), 32'(e.ack));
          check("sb_wd_err", 32'(bus.wd_err), 32'(e.wd));
          check("sb_busy", 32'(bus.busy), 32'd1);
          check("sb_outputs_held", 32'(held_bad), 32'd0);
          if (e.len >= 0) check("sb_grant_len", 32'(glen), 32'(e.len));
        end
      end
    end else if (gprev != 2'd0) begin
      check("release_outputs_zero", 32'({outs, ack, bus.busy, bus.wd_err}), 32'd0);
      zlen = 1;
    end else begin
      zlen++;
    end
    gprev = bus.grant;
  end

  task automatic clear_inputs();
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0; bus.op_req = 1'b0; bus.op_code = 7'h00;
    bus.l2_ready_i = 1'b0; bus.l2_ready_d = 1'b0; bus.l2_ready_op = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_txn(input txn_t t);
    int  cyc;
    sb_t e;
    logic last;
    e.grant = t.exp_grant; e.i_op = t.exp_i_op; e.d_op = t.exp_d_op; e.op = t.exp_op;
    e.ack = t.exp_ack; e.wd = 1'b0; e.len = t.delay;
    @(posedge clk); #1;
    sbq.push_back(e);
    bus.i_req = (t.kind == K_I); bus.d_req = (t.kind == K_D); bus.op_req = (t.kind == K_OP);
    bus.d_we = t.d_we; bus.op_code = t.op_code;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (bus.grant == 2'd0 && cyc < 20);
    check({t.name, "_req_to_grant"}, 32'(cyc), 32'd1);
    for (int k = 1; k <= t.delay; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      last = (k == t.delay);
      // Strobes for the other owners are driven as noise while this grant waits.
      case (t.kind)
        K_I:     begin bus.l2_ready_i = last; bus.l2_ready_d = !last; bus.l2_ready_op = !last; end
        K_D:     begin bus.l2_ready_d = last; bus.l2_ready_i = !last; bus.l2_ready_op = !last; end
        default: begin bus.l2_ready_op = (k == 1) || last; bus.l2_ready_i = !last; bus.l2_ready_d = !last; end
      endcase
      if (t.drop && k == 1 && !last) begin
        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.op_req = 1'b0;
        bus.d_we = ~t.d_we; bus.op_code = ~t.op_code;
      end
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  // Acts as the L2 for whichever owner is granted; optionally drops that requester afterwards.
  task automatic serve_one(input logic drop_req);
    int cyc;
    logic [1:0] g;
    cyc = 0;
    while (bus.grant == 2'd0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("serve_wait_grant", 32'(cyc < 20), 32'd1);
    g = bus.grant;
    if (g == 2'd3) begin
      bus.l2_ready_op = 1'b1; @(posedge clk); #1;
      bus.l2_ready_op = 1'b0; @(posedge clk); #1;
      bus.l2_ready_op = 1'b1;
    end else begin
      bus.l2_ready_i = (g == 2'd1);
      bus.l2_ready_d = (g == 2'd2);
    end
    @(posedge clk); #1;
    bus.l2_ready_i = 1'b0; bus.l2_ready_d = 1'b0; bus.l2_ready_op = 1'b0;
    if (drop_req) begin
      if (g == 2'd1) bus.i_req = 1'b0;
      if (g == 2'd2) bus.d_req = 1'b0;
      if (g == 2'd3) bus.op_req = 1'b0;
    end
  endtask

  txn_t tbl[9];
  logic [1:0] order[6];

  initial begin
    int cyc;
    tbl[0] = '{"i_5cyc",     K_I,  1'b0, 7'h00, 5, 1'b0, 2'd1, 1'b1, 2'b00, 7'h00, 3'b001};
    tbl[1] = '{"i_1cyc",     K_I,  1'b0, 7'h00, 1, 1'b0, 2'd1, 1'b1, 2'b00, 7'h00, 3'b001};
    tbl[2] = '{"d_wr",       K_D,  1'b1, 7'h00, 2, 1'b0, 2'd2, 1'b0, 2'b10, 7'h00, 3'b010};
    tbl[3] = '{"d_rd",       K_D,  1'b0, 7'h00, 1, 1'b0, 2'd2, 1'b0, 2'b01, 7'h00, 3'b010};
    tbl[4] = '{"d_wr_drop",  K_D,  1'b1, 7'h00, 4, 1'b1, 2'd2, 1'b0, 2'b10, 7'h00, 3'b010};
    tbl[5] = '{"op_04",      K_OP, 1'b0, 7'h04, 3, 1'b0, 2'd3, 1'b0, 2'b00, 7'h04, 3'b100};
    tbl[6] = '{"op_02_drop", K_OP, 1'b0, 7'h02, 6, 1'b1, 2'd3, 1'b0, 2'b00, 7'h02, 3'b100};
    tbl[7] = '{"op_7f",      K_OP, 1'b0, 7'h7f, 3, 1'b0, 2'd3, 1'b0, 2'b00, 7'h7f, 3'b100};
    tbl[8] = '{"i_drop",     K_I,  1'b0, 7'h00, 3, 1'b1, 2'd1, 1'b1, 2'b00, 7'h00, 3'b001};
`ifdef L2ARB_ROUND_ROBIN_EN
    order = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
`else
    order = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2};
`endif

    clear_inputs();
    bus.l2_init = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", 32'({bus.grant, bus.busy, bus.i_op, bus.d_op, bus.op,
                              bus.i_ack, bus.d_ack, bus.op_ack, bus.wd_err}), 32'd0);

    // No grant until the L2 leaves INIT.
    @(posedge clk); #1 bus.d_req = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("no_grant_while_init_low", 32'(bus.grant), 32'd0);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    bus.l2_init = 1'b1;

    foreach (tbl[i]) run_txn(tbl[i]);

    // OP outranks simultaneous I and D, then D before I.
    reset_dut();
    sbq.push_back(mk(2'd3, 1'b0, 7'h04, 3));
    sbq.push_back(mk(2'd2, 1'b0, 7'h00, 1));
    sbq.push_back(mk(2'd1, 1'b0, 7'h00, 1));
    bus.op_req = 1'b1; bus.op_code = 7'h04; bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b0;
    repeat (3) serve_one(1'b1);

    // Both I and D held high continuously: grant order depends on arbitration mode.
    reset_dut();
    foreach (order[i]) sbq.push_back(mk(order[i], 1'b1, 7'h00, 1));
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b1;
    repeat (6) serve_one(1'b0);
    bus.i_req = 1'b0; bus.d_req = 1'b0;

    // Watchdog: D write never completed.
    reset_dut();
    begin
      sb_t w;
      w = mk(2'd2, 1'b1, 7'h00, WD);
      w.ack = 3'b000;
      w.wd  = 1'b1;
      sbq.push_back(w);
    end
    bus.d_req = 1'b1; bus.d_we = 1'b1;
    cyc = 0;
    while (bus.grant == 2'd0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    cyc = 0;
    while (bus.grant != 2'd0 && cyc < 400) begin @(posedge clk); #1; cyc++; end
    check("wd_grant_released", 32'(cyc < 400), 32'd1);
    bus.d_req = 1'b0;

    // Reset in the middle of a D grant with ready asserted: no ack, everything cleared.
    reset_dut();
    bus.d_req = 1'b1; bus.d_we = 1'b1;
    cyc = 0;
    while (bus.grant == 2'd0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("rst_seq_granted_d", 32'(bus.grant), 32'd2);
    @(posedge clk); #1;
    rst = 1'b1; bus.l2_ready_d = 1'b1;
    @(negedge clk);
    check("rst_no_d_ack", 32'(bus.d_ack), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.l2_ready_d = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    check("rst_outputs_cleared", 32'({bus.grant, bus.busy, bus.i_op, bus.d_op, bus.op,
                                      bus.i_ack, bus.d_ack, bus.op_ack, bus.wd_err}), 32'd0);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
